ioctl_loader: RTL

Core-side responder for the HPS ioctl download bus. It accepts byte writes from the HPS during ROM download (index 0) and forwards each one to one of four ROM regions through a write port with an acknowledge, holding off the HPS with `o_IOCTL_WAIT`. It captures DIP-switch bytes sent under index 254. It also reports load completion to the core's reset logic.

---
 rtl/ioctl_loader_pkg.sv | 18 +
 rtl/ioctl_region_decode.sv | 38 +++
 rtl/ioctl_loader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ioctl_loader_pkg.sv
// Shared constants and types for the HPS ioctl download responder.
// Stream indices, DIP byte count, region count and the write-handshake FSM states.
package ioctl_loader_pkg;

  localparam int ADDR_W    = 27;
  localparam int OFFSET_W  = 24;
  localparam int N_REGIONS = 4;
  localparam int DIP_BYTES = 8;

  localparam logic [15:0] IDX_ROM   = 16'd0;
  localparam logic [15:0] IDX_DIPSW = 16'd254;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

endpackage

// File: rtl/ioctl_region_decode.sv
// Combinational ROM address decoder: byte address -> one-hot region select,
// offset within that region, and an out-of-range flag for addresses >= ROM_END.
module ioctl_region_decode
  import ioctl_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] R1_BASE = 27'h001_0000,
  parameter logic [ADDR_W-1:0] R2_BASE = 27'h002_0000,
  parameter logic [ADDR_W-1:0] R3_BASE = 27'h004_0000,
  parameter logic [ADDR_W-1:0] ROM_END = 27'h006_0000
) (
  input  logic [ADDR_W-1:0]    i_addr,
  output logic [N_REGIONS-1:0] o_sel,
  output logic [OFFSET_W-1:0]  o_offset,
  output logic                 o_oor
);

  always_comb begin
    o_sel    = '0;
    o_offset = '0;
    o_oor    = 1'b0;
    if (i_addr >= ROM_END) begin
      o_oor = 1'b1;
    end else if (i_addr >= R3_BASE) begin
      o_sel    = 4'b1000;
      o_offset = OFFSET_W'(i_addr - R3_BASE);
    end else if (i_addr >= R2_BASE) begin
      o_sel    = 4'b0100;
      o_offset = OFFSET_W'(i_addr - R2_BASE);
    end else if (i_addr >= R1_BASE) begin
      o_sel    = 4'b0010;
      o_offset = OFFSET_W'(i_addr - R1_BASE);
    end else begin
      o_sel    = 4'b0001;
      o_offset = OFFSET_W'(i_addr);
    end
  end

endmodule

// File: rtl/ioctl_loader.sv
// HPS ioctl download responder: forwards ROM bytes (index 0) to four regions with
// a held request/ack handshake, captures DIP bytes (index 254), reports load done.
// Optional running ROM checksum is enabled by defining IOCTL_LOADER_CHECKSUM_EN.
module ioctl_loader
  import ioctl_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] R1_BASE = 27'h001_0000,
  parameter logic [ADDR_W-1:0] R2_BASE = 27'h002_0000,
  parameter logic [ADDR_W-1:0] R3_BASE = 27'h004_0000,
  parameter logic [ADDR_W-1:0] ROM_END = 27'h006_0000
) (
  input  logic                   i_HPSIO_CLK,
  input  logic                   i_RST,
  input  logic                   i_IOCTL_DOWNLOAD,
  input  logic [15:0]            i_IOCTL_INDEX,
  input  logic [ADDR_W-1:0]      i_IOCTL_ADDR,
  input  logic [7:0]             i_IOCTL_DATA,
  input  logic                   i_IOCTL_WR,
  output logic                   o_IOCTL_WAIT,
  output logic [N_REGIONS-1:0]   o_ROM_SEL,
  output logic [OFFSET_W-1:0]    o_ROM_ADDR,
  output logic [7:0]             o_ROM_DATA,
  output logic                   o_ROM_WR,
  input  logic                   i_ROM_ACK,
  output logic [8*DIP_BYTES-1:0] o_DIPSW,
  output logic                   o_ROM_LOADED,
  output logic                   o_ADDR_ERR,
  output logic                   o_PROTO_ERR,
  output logic [7:0]             o_ROM_CHECKSUM
);

  // Handshake: o_ROM_WR rises one cycle after the strobe and holds SEL/ADDR/DATA
  // constant until the cycle i_ROM_ACK is seen high; o_IOCTL_WAIT mirrors o_ROM_WR.
  state_e                 state_q, state_d;
  logic                   wr_prev_q, dl_prev_q;
  logic [N_REGIONS-1:0]   sel_q, sel_d;
  logic [OFFSET_W-1:0]    addr_q, addr_d;
  logic [7:0]             data_q, data_d;
  logic [8*DIP_BYTES-1:0] dipsw_q, dipsw_d;
  logic                   loaded_q, loaded_d;
  logic                   load_pend_q, load_pend_d;
  logic                   got_byte_q, got_byte_d;
  logic                   addr_err_q, addr_err_d;
  logic                   proto_err_q, proto_err_d;

  logic [N_REGIONS-1:0] dec_sel;
  logic [OFFSET_W-1:0]  dec_offset;
  logic                 dec_oor;
  logic                 wr_edge, dl_rise, dl_fall, rom_start, rom_strobe, dip_strobe;
  logic                 accept;

  ioctl_region_decode #(
    .R1_BASE(R1_BASE),
    .R2_BASE(R2_BASE),
    .R3_BASE(R3_BASE),
    .ROM_END(ROM_END)
  ) u_decode (
    .i_addr  (i_IOCTL_ADDR),
    .o_sel   (dec_sel),
    .o_offset(dec_offset),
    .o_oor   (dec_oor)
  );

  assign wr_edge    = i_IOCTL_WR & ~wr_prev_q;
  assign dl_rise    = i_IOCTL_DOWNLOAD & ~dl_prev_q;
  assign dl_fall    = ~i_IOCTL_DOWNLOAD & dl_prev_q;
  assign rom_start  = dl_rise && (i_IOCTL_INDEX == IDX_ROM);
  assign rom_strobe = wr_edge && i_IOCTL_DOWNLOAD && (i_IOCTL_INDEX == IDX_ROM);
  assign dip_strobe = wr_edge && i_IOCTL_DOWNLOAD && (i_IOCTL_INDEX == IDX_DIPSW);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    data_d      = data_q;
    dipsw_d     = dipsw_q;
    addr_err_d  = addr_err_q;
    proto_err_d = proto_err_q;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rom_strobe) begin
          if (dec_oor) begin
            addr_err_d = 1'b1;
          end else begin
            state_d = PEND;
            sel_d   = dec_sel;
            addr_d  = dec_offset;
            data_d  = i_IOCTL_DATA;
            accept  = 1'b1;
          end
        end
        if (dip_strobe && (i_IOCTL_ADDR < ADDR_W'(DIP_BYTES))) begin
          dipsw_d[8*i_IOCTL_ADDR[2:0] +: 8] = i_IOCTL_DATA;
        end
      end
      PEND: begin
        if (wr_edge) proto_err_d = 1'b1;
        if (i_ROM_ACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A download that ends while a write is still pending only reports loaded
  // once the FSM is back in IDLE.
  always_comb begin
    loaded_d    = loaded_q;
    load_pend_d = load_pend_q;
    got_byte_d  = got_byte_q;
    if (dl_rise) got_byte_d = 1'b0;
    if (rom_start) begin
      loaded_d    = 1'b0;
      load_pend_d = 1'b0;
    end
    if (accept) got_byte_d = 1'b1;
    if (dl_fall && (i_IOCTL_INDEX == IDX_ROM) && got_byte_q) load_pend_d = 1'b1;
    if (load_pend_d && (state_q == IDLE)) begin
      loaded_d    = 1'b1;
      load_pend_d = 1'b0;
    end
  end

  always_ff @(posedge i_HPSIO_CLK) begin
    if (i_RST) begin
      state_q     <= IDLE;
      wr_prev_q   <= 1'b0;
      dl_prev_q   <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      dipsw_q     <= '1;
      loaded_q    <= 1'b0;
      load_pend_q <= 1'b0;
      got_byte_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_prev_q   <= i_IOCTL_WR;
      dl_prev_q   <= i_IOCTL_DOWNLOAD;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      dipsw_q     <= dipsw_d;
      loaded_q    <= loaded_d;
      load_pend_q <= load_pend_d;
      got_byte_q  <= got_byte_d;
      addr_err_q  <= addr_err_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef IOCTL_LOADER_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (rom_start) checksum_d = '0;
    if (accept) checksum_d = checksum_d + i_IOCTL_DATA;
  end

  always_ff @(posedge i_HPSIO_CLK) begin
    if (i_RST) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign o_ROM_CHECKSUM = checksum_q;
`else
  assign o_ROM_CHECKSUM = 8'h00;
`endif

  assign o_IOCTL_WAIT = (state_q == PEND);
  assign o_ROM_WR     = (state_q == PEND);
  assign o_ROM_SEL    = sel_q;
  assign o_ROM_ADDR   = addr_q;
  assign o_ROM_DATA   = data_q;
  assign o_DIPSW      = dipsw_q;
  assign o_ROM_LOADED = loaded_q;
  assign o_ADDR_ERR   = addr_err_q;
  assign o_PROTO_ERR  = proto_err_q;

endmodule
